// File: rtl/vip_gaussian_filter_5x5_8bit_pkg.sv
// Shared constants and types for the 5x5 Gaussian smoothing stage.
//   Kernel: outer product of [1 4 6 4 1] with itself (sum 256).
//   Widths: 8-bit pixels, 12-bit row sums, 16-bit column sum.
//   Normalisation: add 128, shift right by 8, clamp to 8 bits.
package vip_gaussian_filter_5x5_8bit_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned ROW_SUM_W = 12;
  localparam int unsigned COL_SUM_W = 16;

  localparam int unsigned TAP_EDGE = 1;
  localparam int unsigned TAP_NEAR = 4;
  localparam int unsigned TAP_MID  = 6;

  // Tap weights expressed as shift amounts: 1 = <<0, 4 = <<2, 6 = <<2 + <<1.
  localparam int unsigned EDGE_SH   = $clog2(TAP_EDGE);
  localparam int unsigned NEAR_SH   = $clog2(TAP_NEAR);
  localparam int unsigned MID_SH_HI = $clog2(TAP_MID) - 1;
  localparam int unsigned MID_SH_LO = $clog2(TAP_MID - (1 << MID_SH_HI));

  localparam int unsigned ROUND_CONST = 128;
  localparam int unsigned NORM_SHIFT  = 8;
  localparam int unsigned PIX_MAX     = (1 << PIX_W) - 1;

  // Window is treated as fully populated once 4 earlier columns/rows exist.
  localparam int unsigned WIN_EDGE = 4;

  // Per-pixel side information carried next to the arithmetic pipeline.
  typedef struct packed {
    logic             valid;
    logic             bypass;
    logic [PIX_W-1:0] p33;
  } side_t;

  function automatic logic [PIX_W-1:0] clamp_pix(input logic [COL_SUM_W:0] v);
    if (v > (COL_SUM_W+1)'(PIX_MAX)) begin
      return '1;
    end
    return v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/vip_gaussian_filter_5x5_8bit_gauss_tap5_sum.sv
// Registered [1 4 6 4 1] weighted sum of five unsigned values, shift-add only.
//   clk, rst : clock, synchronous active-high reset
//   en       : capture enable; register holds when low
//   x0..x4   : inputs (IN_W bits), x0 is the oldest tap
//   sum      : registered weighted sum (OUT_W bits)
module gauss_tap5_sum
  import vip_gaussian_filter_5x5_8bit_pkg::*;
#(
  parameter int unsigned IN_W  = PIX_W,
  parameter int unsigned OUT_W = ROW_SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  x0,
  input  logic [IN_W-1:0]  x1,
  input  logic [IN_W-1:0]  x2,
  input  logic [IN_W-1:0]  x3,
  input  logic [IN_W-1:0]  x4,
  output logic [OUT_W-1:0] sum
);

  logic [OUT_W-1:0] e0, e1, e2, e3, e4;
  logic [OUT_W-1:0] weighted;

  always_comb begin
    e0 = OUT_W'(x0);
    e1 = OUT_W'(x1);
    e2 = OUT_W'(x2);
    e3 = OUT_W'(x3);
    e4 = OUT_W'(x4);
    weighted = (e0 << EDGE_SH) + (e1 << NEAR_SH) + (e2 << MID_SH_HI) + (e2 << MID_SH_LO)
             + (e3 << NEAR_SH) + (e4 << EDGE_SH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
    end else if (en) begin
      sum <= weighted;
    end
  end

endmodule

// File: rtl/vip_gaussian_filter_5x5_8bit.sv
// Pipelined 5x5 Gaussian smoothing of 8-bit luma, fixed 3-cycle latency.
//   clk, rst                 : pixel clock, synchronous active-high reset
//   bypass                   : per-pixel passthrough of the centre pixel p33
//   matrix_frame_vsync/href/clken : sync from the matrix generator
//   matrix_p11..matrix_p55   : 5x5 window, row 1 / column 1 oldest
//   post_frame_vsync/href/clken   : sync delayed by 3 cycles
//   post_img_y               : filtered pixel (p33 at window borders, 0 when href low)
module vip_gaussian_filter_5x5_8bit
  import vip_gaussian_filter_5x5_8bit_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bypass,
  input  logic             matrix_frame_vsync,
  input  logic             matrix_frame_href,
  input  logic             matrix_frame_clken,
  input  logic [PIX_W-1:0] matrix_p11,
  input  logic [PIX_W-1:0] matrix_p12,
  input  logic [PIX_W-1:0] matrix_p13,
  input  logic [PIX_W-1:0] matrix_p14,
  input  logic [PIX_W-1:0] matrix_p15,
  input  logic [PIX_W-1:0] matrix_p21,
  input  logic [PIX_W-1:0] matrix_p22,
  input  logic [PIX_W-1:0] matrix_p23,
  input  logic [PIX_W-1:0] matrix_p24,
  input  logic [PIX_W-1:0] matrix_p25,
  input  logic [PIX_W-1:0] matrix_p31,
  input  logic [PIX_W-1:0] matrix_p32,
  input  logic [PIX_W-1:0] matrix_p33,
  input  logic [PIX_W-1:0] matrix_p34,
  input  logic [PIX_W-1:0] matrix_p35,
  input  logic [PIX_W-1:0] matrix_p41,
  input  logic [PIX_W-1:0] matrix_p42,
  input  logic [PIX_W-1:0] matrix_p43,
  input  logic [PIX_W-1:0] matrix_p44,
  input  logic [PIX_W-1:0] matrix_p45,
  input  logic [PIX_W-1:0] matrix_p51,
  input  logic [PIX_W-1:0] matrix_p52,
  input  logic [PIX_W-1:0] matrix_p53,
  input  logic [PIX_W-1:0] matrix_p54,
  input  logic [PIX_W-1:0] matrix_p55,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [PIX_W-1:0] post_img_y
);

  localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT - 1);

  logic [PIX_W-1:0] win [5][5];

  assign win[0][0] = matrix_p11;
  assign win[0][1] = matrix_p12;
  assign win[0][2] = matrix_p13;
  assign win[0][3] = matrix_p14;
  assign win[0][4] = matrix_p15;
  assign win[1][0] = matrix_p21;
  assign win[1][1] = matrix_p22;
  assign win[1][2] = matrix_p23;
  assign win[1][3] = matrix_p24;
  assign win[1][4] = matrix_p25;
  assign win[2][0] = matrix_p31;
  assign win[2][1] = matrix_p32;
  assign win[2][2] = matrix_p33;
  assign win[2][3] = matrix_p34;
  assign win[2][4] = matrix_p35;
  assign win[3][0] = matrix_p41;
  assign win[3][1] = matrix_p42;
  assign win[3][2] = matrix_p43;
  assign win[3][3] = matrix_p44;
  assign win[3][4] = matrix_p45;
  assign win[4][0] = matrix_p51;
  assign win[4][1] = matrix_p52;
  assign win[4][2] = matrix_p53;
  assign win[4][3] = matrix_p54;
  assign win[4][4] = matrix_p55;

  // Stage 0: position counters on the input side.
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             vsync_q;
  logic             href_q;
  logic             win_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= matrix_frame_vsync;
      href_q  <= matrix_frame_href;
      if (!matrix_frame_href) begin
        col_cnt <= '0;
      end else if (matrix_frame_clken && col_cnt != COL_MAX) begin
        col_cnt <= col_cnt + 1'b1;
      end
      // vsync rising edge takes priority over a coincident href falling edge.
      if (matrix_frame_vsync && !vsync_q) begin
        row_cnt <= '0;
      end else if (href_q && !matrix_frame_href && row_cnt != ROW_MAX) begin
        row_cnt <= row_cnt + 1'b1;
      end
    end
  end

  assign win_valid = (32'(col_cnt) >= WIN_EDGE) && (32'(row_cnt) >= WIN_EDGE);

  // Sync delay line; bit k is the input delayed by k+1 cycles.
  logic [2:0] vsync_d, href_d, clken_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d <= '0;
      href_d  <= '0;
      clken_d <= '0;
    end else begin
      vsync_d <= {vsync_d[1:0], matrix_frame_vsync};
      href_d  <= {href_d[1:0],  matrix_frame_href};
      clken_d <= {clken_d[1:0], matrix_frame_clken};
    end
  end

  assign post_frame_vsync = vsync_d[2];
  assign post_frame_href  = href_d[2];
  assign post_frame_clken = clken_d[2];

  // Stage 1: row pass.
  logic [ROW_SUM_W-1:0] row_sum [5];

  for (genvar r = 0; r < 5; r++) begin : g_row
    gauss_tap5_sum #(
      .IN_W  (PIX_W),
      .OUT_W (ROW_SUM_W)
    ) u_row (
      .clk (clk),
      .rst (rst),
      .en  (matrix_frame_clken),
      .x0  (win[r][0]),
      .x1  (win[r][1]),
      .x2  (win[r][2]),
      .x3  (win[r][3]),
      .x4  (win[r][4]),
      .sum (row_sum[r])
    );
  end

  // Stage 2: column pass.
  logic [COL_SUM_W-1:0] col_sum;

  gauss_tap5_sum #(
    .IN_W  (ROW_SUM_W),
    .OUT_W (COL_SUM_W)
  ) u_col (
    .clk (clk),
    .rst (rst),
    .en  (clken_d[0]),
    .x0  (row_sum[0]),
    .x1  (row_sum[1]),
    .x2  (row_sum[2]),
    .x3  (row_sum[3]),
    .x4  (row_sum[4]),
    .sum (col_sum)
  );

  // Side pipeline, enabled exactly like the arithmetic stages it shadows.
  side_t side_s1, side_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      side_s1 <= '0;
      side_s2 <= '0;
    end else begin
      if (matrix_frame_clken) begin
        side_s1 <= '{valid: win_valid, bypass: bypass, p33: matrix_p33};
      end
      if (clken_d[0]) begin
        side_s2 <= side_s1;
      end
    end
  end

  // Stage 3: normalise, clamp, select.
  logic [COL_SUM_W:0] rounded;
  logic [COL_SUM_W:0] norm;
  logic [PIX_W-1:0]   y_sel;

  always_comb begin
    rounded = {1'b0, col_sum} + (COL_SUM_W+1)'(ROUND_CONST);
    norm    = rounded >> NORM_SHIFT;
    if (side_s2.bypass || !side_s2.valid) begin
      y_sel = side_s2.p33;
    end else begin
      y_sel = clamp_pix(norm);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      post_img_y <= '0;
    end else if (!href_d[1]) begin
      post_img_y <= '0;
    end else if (clken_d[1]) begin
      post_img_y <= y_sel;
    end
  end

endmodule
